// File: rtl/servo_pwm_pkg.sv
// Shared constants and the slew helper for the servo PWM array.
package servo_pwm_pkg;

  // Word addresses of the register map.
  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_PERIOD   = 1;
  localparam int unsigned ADDR_MAX_STEP = 2;
  localparam int unsigned ADDR_STATUS   = 3;
  localparam int unsigned ADDR_TARGET0  = 4;

  // CTRL bit positions.
  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_SLEW_EN = 1;
  localparam int unsigned CTRL_HOLD    = 2;
  localparam int unsigned CTRL_W       = 3;

  // Slew arithmetic is done one bit wider than the widest supported counter, so
  // cur +/- step can never wrap.
  localparam int unsigned SLEW_W = 33;

  // Move cur toward tgt by at most step; step == 0 or limit == 0 jumps straight to tgt.
  // The result always lies between cur and tgt, so it fits the caller's duty width.
  function automatic logic [SLEW_W-1:0] slew_next(input logic [SLEW_W-1:0] cur,
                                                  input logic [SLEW_W-1:0] tgt,
                                                  input logic [SLEW_W-1:0] step,
                                                  input logic              limit);
    logic [SLEW_W-1:0] res;
    logic [SLEW_W-1:0] diff;
    res  = tgt;
    diff = '0;
    if (limit && (step != '0)) begin
      if (tgt >= cur) begin
        diff = tgt - cur;
        if (diff > step) res = cur + step;
      end else begin
        diff = cur - tgt;
        if (diff > step) res = cur - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: shadow target, active duty and the output comparator.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tgt_we_i,
  input  logic [CNT_W-1:0] tgt_wdata_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             enable_i,
  input  logic             update_i,
  input  logic             load_i,
  input  logic             slew_i,
  input  logic [CNT_W-1:0] max_step_i,
  output logic [CNT_W-1:0] target_o,
  output logic             pwm_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  // Next-state: shadow write, boundary slew/copy or direct load, and the comparator.
  always_comb begin
    target_d = target_q;
    if (tgt_we_i) target_d = tgt_wdata_i;

    duty_d = duty_q;
    if (load_i) begin
      duty_d = target_q;
    end else if (update_i) begin
      duty_d = CNT_W'(slew_next(SLEW_W'(duty_q), SLEW_W'(target_q), SLEW_W'(max_step_i),
                                slew_i));
    end

    // Compares against the current duty; the new duty is seen from cnt = 0 onwards.
    pwm_d = enable_i && (cnt_i < duty_q);
  end

  // Channel state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      target_q <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
    end
  end

  assign target_o = target_q;
  assign pwm_o    = pwm_q;
  assign busy_o   = (duty_q != target_q);

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel frame-aligned servo PWM generator with an Avalon-MM register file.
module servo_pwm_array
  import servo_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = 18,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned PERIOD_RST = 1000000,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_start
);

  localparam logic [CNT_W-1:0] PeriodRst = CNT_W'(PERIOD_RST);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  max_step_q, max_step_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_start_q, frame_start_d;
  logic [31:0]       rd_q, rd_d;

  logic enable, hold, slew_on;
  logic ctrl_wr, en_rise, load, wrap, update;

  logic [NUM_CH-1:0]            tgt_we;
  logic [NUM_CH-1:0][CNT_W-1:0] target_w;
  logic [NUM_CH-1:0]            busy_w;

  // Only the low CNT_W / CTRL bits are stored; the rest of the write bus is ignored.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign enable  = ctrl_q[CTRL_ENABLE];
  assign hold    = ctrl_q[CTRL_HOLD];
  assign slew_on = ctrl_q[CTRL_SLEW_EN] && (max_step_q != '0);

  // Frame boundary detection and enable-rise load.
  always_comb begin
    ctrl_wr = avs_write && (avs_address == ADDR_W'(ADDR_CTRL));
    en_rise = ctrl_wr && !enable && avs_writedata[CTRL_ENABLE];
    // Load on rise follows the hold bit being written, not the old one.
    load    = en_rise && !avs_writedata[CTRL_HOLD];
    // Periods of 0 and 1 both mean every cycle is the last of its frame.
    wrap    = enable && ((period_act_q <= CNT_W'(1)) ||
                         (cnt_q >= period_act_q - CNT_W'(1)));
    update  = wrap && !hold;
  end

  // Register writes, frame counter and active period next-state.
  always_comb begin
    ctrl_d     = ctrl_q;
    period_d   = period_q;
    max_step_d = max_step_q;
    if (avs_write) begin
      if (avs_address == ADDR_W'(ADDR_CTRL))     ctrl_d     = avs_writedata[CTRL_W-1:0];
      if (avs_address == ADDR_W'(ADDR_PERIOD))   period_d   = avs_writedata[CNT_W-1:0];
      if (avs_address == ADDR_W'(ADDR_MAX_STEP)) max_step_d = avs_writedata[CNT_W-1:0];
    end

    period_act_d = period_act_q;
    if (load || update) period_act_d = period_q;

    if (!enable || wrap) cnt_d = '0;
    else                 cnt_d = cnt_q + CNT_W'(1);

    frame_start_d = wrap || en_rise;
  end

  // Read mux; the registered value holds until the next read.
  always_comb begin
    rd_d = rd_q;
    if (avs_read) begin
      rd_d = '0;
      if (avs_address == ADDR_W'(ADDR_CTRL))     rd_d[CTRL_W-1:0] = ctrl_q;
      if (avs_address == ADDR_W'(ADDR_PERIOD))   rd_d[CNT_W-1:0]  = period_q;
      if (avs_address == ADDR_W'(ADDR_MAX_STEP)) rd_d[CNT_W-1:0]  = max_step_q;
      if (avs_address == ADDR_W'(ADDR_STATUS))   rd_d[0]          = |busy_w;
      for (int i = 0; i < NUM_CH; i++) begin
        if (avs_address == ADDR_W'(ADDR_TARGET0 + i)) rd_d[CNT_W-1:0] = target_w[i];
      end
    end
  end

  // Top-level state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= '0;
      period_q      <= PeriodRst;
      max_step_q    <= '0;
      period_act_q  <= PeriodRst;
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      rd_q          <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      period_q      <= period_d;
      max_step_q    <= max_step_d;
      period_act_q  <= period_act_d;
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      rd_q          <= rd_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign tgt_we[i] = avs_write && (avs_address == ADDR_W'(ADDR_TARGET0 + i));

    servo_pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i       (clk),
      .reset_i     (reset),
      .tgt_we_i    (tgt_we[i]),
      .tgt_wdata_i (avs_writedata[CNT_W-1:0]),
      .cnt_i       (cnt_q),
      .enable_i    (enable),
      .update_i    (update),
      .load_i      (load),
      .slew_i      (slew_on),
      .max_step_i  (max_step_q),
      .target_o    (target_w[i]),
      .pwm_o       (pwm[i]),
      .busy_o      (busy_w[i])
    );
  end

  assign avs_readdata = rd_q;
  assign frame_start  = frame_start_q;

endmodule

// File: doc/servo_pwm_array.md
# servo_pwm_array

Parametrised multi-channel servo PWM generator with an Avalon-MM slave register interface, generalising the fixed per-servo PWM peripherals of the leg controller into one block. It drives NUM_CH frame-aligned PWM outputs from one shared frame counter. Duty targets are double-buffered, so the HPS can update all channels atomically. A per-frame slew limit gives smooth joint motion. It sits on the lightweight HPS-to-FPGA bridge, and its pwm bus goes to the leg servo headers.

## Interface
Parameters:
- NUM_CH, 18, number of PWM channels (1..28)
- CNT_W, 20, frame counter / period / duty width (≤ 32)
- PERIOD_RST, 1000000, reset frame period in clocks (20 ms at 50 MHz)
- ADDR_W, 5, word address width; 2**ADDR_W ≥ 4+NUM_CH

Ports:
- clk  in  1  single clock for the whole block
- reset  in  1  synchronous, active-high
- avs_address  in  ADDR_W  word address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, fixed read latency 1
- pwm  out  NUM_CH  registered PWM outputs; bit i is channel i
- frame_start  out  1  one-cycle pulse at each frame start

## Operation
- Register map (word addresses):
  - 0 CTRL: bit0 enable, bit1 slew_en, bit2 hold
  - 1 PERIOD: period in clocks, low CNT_W bits
  - 2 MAX_STEP: largest duty change per frame, in clocks; 0 means unlimited
  - 3 STATUS (read-only): bit0 = 1 while any active duty ≠ its target
  - 4..4+NUM_CH-1 TARGET[i]: duty target for channel i
- Unmapped reads return 0. Unmapped writes and writes to STATUS are ignored. Register bits above CNT_W read as 0.
- Shadow versus active:
  - PERIOD and TARGET[i] are shadow registers.
  - The active period and active duty[i] change only at a frame boundary, and only when hold = 0.
- Frame counter:
  - cnt counts 0..active_period-1, then wraps to 0. The wrap is the frame boundary.
  - An active period of 0 or 1 behaves as 1: cnt stays at 0 and every cycle is a boundary.
- Boundary update, when hold = 0:
  - active_period ← PERIOD.
  - When slew_en = 0 or MAX_STEP = 0: active duty[i] ← TARGET[i].
  - Otherwise, active duty[i] moves toward TARGET[i] by min(|TARGET−active|, MAX_STEP).
  - All slew arithmetic uses CNT_W+1 bits and cannot overshoot or wrap.
- Output: pwm[i] ← enable & (cnt < active_duty[i]).
  - Duty 0 gives a constant low output.
  - Duty ≥ active_period gives a constant high output.
- Enable = 0:
  - cnt is held at 0, pwm is all low, and no boundaries or frame_start pulses occur.
  - On the 0→1 transition of enable, with hold = 0, the active period and every active duty load their shadows directly, with no slew. Counting then starts from 0.
- Hold = 1 freezes the active values; the counter keeps running. Software uses this for atomic multi-channel updates: set hold, write targets, clear hold. The new values apply at the next boundary.
- Simultaneous events:
  - A write to TARGET[i] in the cycle of a boundary does not take effect at that boundary; the boundary uses the pre-write shadow.
  - A read and a write to the same address in one cycle return the old value.

## Timing
- Reset values:
  - CTRL = 0, PERIOD = PERIOD_RST, MAX_STEP = 0, TARGET = 0.
  - Active period = PERIOD_RST, active duty = 0, cnt = 0.
  - pwm = 0, frame_start = 0, avs_readdata = 0.
- avs_readdata is valid in the cycle after avs_read and holds until the next read.
- The active-value update and the cnt→0 transition happen on the same clock edge.
- pwm is registered, so it lags cnt by one cycle. The first pwm cycle of a frame already uses the new active duty.
- frame_start is high in the cycle in which cnt = 0 after a wrap or after an enable rise.
- Reset asserted mid-frame: all state returns to its reset value on the next edge, and pwm is low the following cycle.

## Structure
- Package servo_pwm_pkg holds:
  - register address constants (ADDR_CTRL, ADDR_PERIOD, ADDR_MAX_STEP, ADDR_STATUS, ADDR_TARGET0);
  - CTRL bit indices;
  - a function computing the slew-limited next duty.
- Sub-module servo_pwm_channel is generated NUM_CH times. Each instance holds the target, active duty and comparator, and takes cnt, boundary and MAX_STEP as inputs.
- The top level holds the register file, frame counter and read mux.

## Test plan
- Reset, then write PERIOD = 100, TARGET[0] = 25, CTRL = 1 → pwm[0] high 25 of every 100 cycles; frame_start pulses every 100 cycles.
- TARGET[1] = 0 and TARGET[2] = 150 with PERIOD = 100 → pwm[1] constantly low, pwm[2] constantly high.
- slew_en = 1, MAX_STEP = 10, TARGET[0] changed from 25 to 58 → high time is 35, 45, 55, 58 over successive frames; STATUS bit0 is 1 until the frame where the active duty equals 58.
- hold = 1, write TARGET[0..17], wait 3 frames → no change in pwm; clear hold → all channels change together at the next frame_start.
- Write TARGET[3] = 40 in the exact boundary cycle → the frame that starts still uses the old duty; the following frame uses 40; a read in the write cycle returns the old value.
- Assert reset mid-frame with duty 50 → pwm all low the next cycle; readback shows PERIOD = PERIOD_RST and TARGET = 0.
